aes_encipher_ctrl: RTL
======================

Name: aes_encipher_ctrl

Overview:
Sequencing controller for the AES encipher round datapath. It drives the round type (init/main/final), the round key address, the 4-step S-box word mux control, and the state-register write strobes. The block sits between the AES core FSM (next/ready) and the combinational encipher round logic and its shared 4-lane S-box. It supports AES-128 (10 rounds) and AES-256 (14 rounds).

Parameters:
AES128_ROUNDS, 10, number of rounds when keylen=0
AES256_ROUNDS, 14, number of rounds when keylen=1

Ports:
clk  in  1  system clock, all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
next  in  1  start one block encipher; sampled only while ready=1
keylen  in  1  0=AES-128, 1=AES-256; latched on an accepted next
round_key_addr  out  4  round key index presented to the key memory
round_type  out  2  0=INIT, 1=MAIN, 2=FINAL, 3=IDLE; datapath outputs zero on 3
sbox_mux_ctrl  out  2  which state row/word is routed through the 4 S-boxes
word_we  out  1  write the S-box substituted word selected by sbox_mux_ctrl into the state
block_we  out  1  write the full 128-bit new_block into the state register
ready  out  1  high when idle and able to accept next
done  out  1  single-cycle pulse on the cycle ready returns high

Behaviour:
- Reset values (async, reset_n=0):
  - State register: IDLE.
  - ready=1, done=0, round_key_addr=0, round_type=3, sbox_mux_ctrl=0, word_we=0, block_we=0.
  - Internal round_ctr=0, sword_ctr=0, keylen_reg=0.
- All outputs are registered or decoded from registered state only. No combinational path from next or keylen to any output.
- States: IDLE, INIT, SBOX, MAIN, FINAL.
- IDLE:
  - round_type=3, strobes low.
  - If next=1: latch keylen, ready<=0, go to INIT.
  - next while ready=0 is ignored, with no queuing.
- INIT (1 cycle):
  - round_type=0, round_key_addr=0, block_we=1.
  - Then round_ctr<=1, sword_ctr<=0, go to SBOX.
- SBOX (exactly 4 cycles):
  - sbox_mux_ctrl=sword_ctr (0,1,2,3 in order), word_we=1 each cycle, round_type=1, round_key_addr=round_ctr.
  - sword_ctr increments and wraps 3->0.
  - After the sword_ctr=3 cycle: go to MAIN if round_ctr < num_rounds, else FINAL.
- MAIN (1 cycle):
  - round_type=1, round_key_addr=round_ctr, block_we=1.
  - round_ctr<=round_ctr+1, go to SBOX.
- FINAL (1 cycle):
  - round_type=2, round_key_addr=num_rounds, block_we=1.
  - Go to IDLE. ready<=1 and done<=1 on the same edge.
  - done falls the next cycle.
- num_rounds = AES128_ROUNDS if keylen_reg=0, else AES256_ROUNDS. Changing keylen mid-operation has no effect.
- Latency: with next accepted at edge E0, INIT occupies cycle 1.
  - AES-128: FINAL in cycle 51; ready/done high in cycle 52 (1 + 10*5 + 1 = 52).
  - AES-256: FINAL in cycle 71; ready/done high in cycle 72.
- word_we and block_we are mutually exclusive. At most one is high in any cycle.
- round_ctr is 4 bits and never exceeds 14. round_key_addr is never > num_rounds.
- Reset asserted mid-operation: immediately returns to the reset values above. No done pulse is emitted. A new next is accepted on the first edge after reset_n rises.
- next held high continuously: a new block starts on the cycle ready is high (cycle 52). Back-to-back throughput is one block per 52 cycles (AES-128).

Test Plan:
- Reset then idle: reset_n=0 mid-cycle -> all outputs at reset values asynchronously; ready=1, round_type=3.
- AES-128 single block: keylen=0, next pulse -> INIT at cycle 1 with addr 0, block_we=1; ten SBOX runs with sbox_mux_ctrl 0,1,2,3; MAIN addresses 1..9; FINAL addr 10 at cycle 51; done pulse at cycle 52; count word_we=40, block_we=11.
- AES-256 single block: keylen=1 -> FINAL addr 14 at cycle 71; done at cycle 72; word_we=56, block_we=15; keylen toggled mid-run has no effect.
- next while busy: pulse next at cycles 5 and 30 -> ignored; exactly one done; ready stays 0 until cycle 52.
- Reset mid-operation: reset_n low at cycle 20 -> immediate IDLE outputs, no done; a fresh next then completes normally in 52 cycles.
- Continuous next=1 -> blocks start at cycles 0 and 52; done pulses at 52 and 104; word_we and block_we never high together (assertion).

Source files
------------

// File: rtl/aes_encipher_ctrl.sv
// AES encipher round sequencer.
// Walks INIT -> (SBOX x4 -> MAIN) x (N-1) -> SBOX x4 -> FINAL for N = 10 or 14
// rounds. It drives round type, round key index, S-box word select and the
// state-register write strobes. Every output is a flop. Each output is loaded
// with the value the next state presents, so the outputs track state_q with no
// added delay.
module aes_encipher_ctrl #(
  parameter int unsigned AES128_ROUNDS = 10,
  parameter int unsigned AES256_ROUNDS = 14
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       next,
  input  logic       keylen,
  output logic [3:0] round_key_addr,
  output logic [1:0] round_type,
  output logic [1:0] sbox_mux_ctrl,
  output logic       word_we,
  output logic       block_we,
  output logic       ready,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SBOX,
    ST_MAIN,
    ST_FINAL
  } state_t;

  typedef enum logic [1:0] {
    RT_INIT  = 2'd0,
    RT_MAIN  = 2'd1,
    RT_FINAL = 2'd2,
    RT_IDLE  = 2'd3
  } round_type_t;

  localparam logic [3:0] NR128 = 4'(AES128_ROUNDS);
  localparam logic [3:0] NR256 = 4'(AES256_ROUNDS);

  state_t      state_q;
  round_type_t round_type_q;
  logic [3:0]  round_ctr_q;
  logic [1:0]  sword_ctr_q;
  logic        keylen_q;
  logic [3:0]  round_key_addr_q;
  logic [1:0]  sbox_mux_ctrl_q;
  logic        word_we_q;
  logic        block_we_q;
  logic        ready_q;
  logic        done_q;
  logic [3:0]  num_rounds;

  // Round count follows the key length latched when the block was accepted.
  always_comb begin
    num_rounds = keylen_q ? NR256 : NR128;
  end

  // Sequencer FSM. Each branch loads the outputs for the state it enters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      round_type_q     <= RT_IDLE;
      round_ctr_q      <= '0;
      sword_ctr_q      <= '0;
      keylen_q         <= 1'b0;
      round_key_addr_q <= '0;
      sbox_mux_ctrl_q  <= '0;
      word_we_q        <= 1'b0;
      block_we_q       <= 1'b0;
      ready_q          <= 1'b1;
      done_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (next) begin
            keylen_q         <= keylen;
            ready_q          <= 1'b0;
            state_q          <= ST_INIT;
            round_type_q     <= RT_INIT;
            round_key_addr_q <= '0;
            sbox_mux_ctrl_q  <= '0;
            word_we_q        <= 1'b0;
            block_we_q       <= 1'b1;
          end
        end

        ST_INIT: begin
          round_ctr_q      <= 4'd1;
          sword_ctr_q      <= '0;
          state_q          <= ST_SBOX;
          round_type_q     <= RT_MAIN;
          round_key_addr_q <= 4'd1;
          sbox_mux_ctrl_q  <= '0;
          word_we_q        <= 1'b1;
          block_we_q       <= 1'b0;
        end

        ST_SBOX: begin
          sword_ctr_q <= sword_ctr_q + 2'd1;
          if (sword_ctr_q != 2'd3) begin
            sbox_mux_ctrl_q <= sword_ctr_q + 2'd1;
          end else begin
            sbox_mux_ctrl_q <= '0;
            word_we_q       <= 1'b0;
            block_we_q      <= 1'b1;
            if (round_ctr_q < num_rounds) begin
              state_q          <= ST_MAIN;
              round_type_q     <= RT_MAIN;
              round_key_addr_q <= round_ctr_q;
            end else begin
              state_q          <= ST_FINAL;
              round_type_q     <= RT_FINAL;
              round_key_addr_q <= num_rounds;
            end
          end
        end

        ST_MAIN: begin
          round_ctr_q      <= round_ctr_q + 4'd1;
          state_q          <= ST_SBOX;
          round_type_q     <= RT_MAIN;
          round_key_addr_q <= round_ctr_q + 4'd1;
          sbox_mux_ctrl_q  <= '0;
          word_we_q        <= 1'b1;
          block_we_q       <= 1'b0;
        end

        ST_FINAL: begin
          state_q          <= ST_IDLE;
          ready_q          <= 1'b1;
          done_q           <= 1'b1;
          round_type_q     <= RT_IDLE;
          round_key_addr_q <= '0;
          sbox_mux_ctrl_q  <= '0;
          word_we_q        <= 1'b0;
          block_we_q       <= 1'b0;
        end

        default: begin
          state_q          <= ST_IDLE;
          ready_q          <= 1'b1;
          round_type_q     <= RT_IDLE;
          round_key_addr_q <= '0;
          sbox_mux_ctrl_q  <= '0;
          word_we_q        <= 1'b0;
          block_we_q       <= 1'b0;
        end
      endcase
    end
  end

  assign round_key_addr = round_key_addr_q;
  assign round_type     = round_type_q;
  assign sbox_mux_ctrl  = sbox_mux_ctrl_q;
  assign word_we        = word_we_q;
  assign block_we       = block_we_q;
  assign ready          = ready_q;
  assign done           = done_q;

endmodule
